mul_shift_add: RTL and testbench
================================

// Module: mul_shift_add
// PURPOSE
//   Sequential unsigned N x N -> 2N multiplier built on one Adder_CLA instance (radix-2 shift-add).
//   Drives the adder's a/b/c_in and consumes sum/c_out once per cycle.
//   Sits between a valid/ready operand source and a valid/ready result sink.
//   Processes one operation at a time; no overlap.
// PARAMETERS
//   N   32   operand width; must be a multiple of 4 (adder slice width); product width is 2N
// PORTS
//   clk        in   1    single clock; all state updates on rising edge
//   rst_n      in   1    asynchronous, active-low reset
//   in_valid   in   1    operand pair valid
//   in_ready   out  1    block can accept operands (IDLE only)
//   in_a       in   N    multiplicand
//   in_b       in   N    multiplier
//   out_valid  out  1    product valid; held until accepted
//   out_ready  in   1    sink accepts product
//   out_prod   out  2N   product a*b
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, out_prod=0, count=0, all regs 0.
//   Registers: mcand[N-1:0]; prod={hi[N-1:0], lo[N-1:0]}; count[$clog2(N):0].
//   Accept: in_valid & in_ready at an edge -> mcand<=in_a, hi<=0, lo<=in_b, count<=0, state<=CALC.
//   Adder hookup: a=hi, b=lo[0] ? mcand : 0, c_in=0.
//   CALC step, each cycle: prod <= {c_out, sum, lo[N-1:1]}; count<=count+1.
//   After N CALC cycles -> DONE. Carry is never lost: hi+mcand <= 2^(N+1)-2, and that carry lands in prod[2N-1].
//   DONE: out_valid=1, out_prod=prod. Stable while out_ready=0.
//   On out_valid & out_ready -> IDLE; out_valid falls on that edge.
//   Latency: out_valid first high N edges after the accepting edge (N+1 with MUL_SIGNED_EN).
//   in_ready=0 in CALC/FIX/DONE. in_valid there is ignored; operands are not captured.
//   out_prod: registered and held after hand-off until next completion; value outside DONE is don't-care to sink.
//   rst_n low mid-CALC/DONE: operation discarded, no output produced; state=IDLE.
//   Zero operand: full N cycles still spent (fixed latency); result 0.
//   Max operands: (2^N-1)^2 = 2^2N - 2^(N+1) + 1, exact, no truncation.
// CONFIGURATION
//   `MUL_SIGNED_EN defined: operands are two's complement, out_prod is signed 2N.
//     Accept: mcand<=|in_a|, lo<=|in_b| (unsigned N-bit magnitudes; -2^(N-1) -> 2^(N-1) fits).
//     Accept also stores neg = in_a[N-1] ^ in_b[N-1].
//     After CALC -> FIX for one cycle: if neg, prod <= ~prod + 1 (2N-bit), else prod unchanged -> DONE.
//   Undefined: pure unsigned; no FIX state or neg register; CALC -> DONE directly.
// STRUCTURE
//   mul_pkg: state enum {IDLE, CALC, FIX, DONE} (2-bit), encoded 0..3.
//   mul_pkg: localparam ADDER_SLICE=4 for the N%4 elaboration check.
//   Sub-module: one Adder_CLA #(.N(N)) instance; the only datapath adder for accumulation.
//   Out-of-range N (N%4!=0 or N<4) -> elaboration $error.
// TESTING
//   N=8, a=13, b=11 -> out_valid 8 edges after accept, out_prod=143; in_ready low throughout.
//   N=8, a=255, b=255 -> out_prod=65025 (0xFE01), carry path exercised every cycle.
//   N=32, a=0 / b=0xFFFFFFFF -> out_prod=0 after 32 cycles; then a=0xFFFFFFFF,b=0xFFFFFFFF -> 0xFFFFFFFE00000001.
//   Backpressure: out_ready=0 for 5 cycles in DONE -> out_prod/out_valid stable, second in_valid ignored.
//   Reset mid-CALC (cycle 3 of 8) -> out_valid stays 0, in_ready=1 after reset.
//   Next op (7*6) -> 42 correct.
//   `MUL_SIGNED_EN, N=8: -128*-128 -> 16384; -3*5 -> 0xFFF1 (-15); both with latency 9.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and constants for the radix-2 shift-add multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Lookahead slice width of Adder_CLA; operand width must be a multiple of it.
    localparam int ADDER_SLICE = 4;

    function automatic bit width_ok(input int n);
        return (n >= ADDER_SLICE) && ((n % ADDER_SLICE) == 0);
    endfunction

endpackage

// File: rtl/mul_shift_add_if.sv
// Operand/result valid-ready bundle for mul_shift_add; slave side is the multiplier.
interface mul_shift_add_if #(
    parameter int N = 32
);

    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   in_a;
    logic [N-1:0]   in_b;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] out_prod;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_prod
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_prod
    );

endinterface

// File: rtl/Adder_CLA.sv
// N-bit adder built from 4-bit carry-lookahead slices, carry rippling between slices.
module Adder_CLA
    import mul_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic [N-1:0] sum,
    output logic         c_out
);

    localparam int SLICES = N / ADDER_SLICE;

    logic [SLICES:0] carry;

    assign carry[0] = c_in;

    for (genvar s = 0; s < SLICES; s++) begin : g_slice
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;

        assign g    = a[4*s +: 4] & b[4*s +: 4];
        assign p    = a[4*s +: 4] ^ b[4*s +: 4];
        assign c[0] = carry[s];
        // Each slice carry is a flat sum-of-products of the slice carry-in.
        assign c[1] = g[0] | (p[0] & c[0]);
        assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                    | (p[2] & p[1] & p[0] & c[0]);
        assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                    | (p[3] & p[2] & p[1] & g[0])
                    | (p[3] & p[2] & p[1] & p[0] & c[0]);

        assign sum[4*s +: 4] = p ^ c[3:0];
        assign carry[s+1]    = c[4];
    end

    assign c_out = carry[SLICES];

endmodule

// File: rtl/mul_shift_add.sv
// Sequential N x N -> 2N shift-add multiplier around one Adder_CLA.
// Define MUL_SIGNED_EN for two's-complement operands (adds a FIX state).
module mul_shift_add
    import mul_pkg::*;
#(
    parameter int N = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    mul_shift_add_if.slave  bus
);

    localparam int CW = $clog2(N) + 1;

    if (!width_ok(N)) begin : g_bad_width
        $error("mul_shift_add: N=%0d must be >= %0d and a multiple of %0d",
               N, ADDER_SLICE, ADDER_SLICE);
    end

    state_t         state;
    state_t         state_next;
    logic [N-1:0]   mcand;
    logic [2*N-1:0] prod;
    logic [CW-1:0]  count;
    logic [N-1:0]   add_b;
    logic [N-1:0]   sum;
    logic           c_out;
    logic           last_step;

`ifdef MUL_SIGNED_EN
    logic           neg;
    logic [N-1:0]   mag_a;
    logic [N-1:0]   mag_b;

    // -2^(N-1) negates to itself, which is the correct unsigned magnitude.
    assign mag_a = bus.in_a[N-1] ? (~bus.in_a + N'(1)) : bus.in_a;
    assign mag_b = bus.in_b[N-1] ? (~bus.in_b + N'(1)) : bus.in_b;
`endif

    assign last_step = (count == CW'(N - 1));
    assign add_b     = prod[0] ? mcand : '0;

    Adder_CLA #(.N(N)) u_adder (
        .a     (prod[2*N-1:N]),
        .b     (add_b),
        .c_in  (1'b0),
        .sum   (sum),
        .c_out (c_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every output gets a default before the case so no path infers a latch.
        state_next    = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_next = CALC;
            end
            CALC: begin
`ifdef MUL_SIGNED_EN
                if (last_step) state_next = FIX;
`else
                if (last_step) state_next = DONE;
`endif
            end
            FIX: state_next = DONE;
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand <= '0;
            prod  <= '0;
            count <= '0;
`ifdef MUL_SIGNED_EN
            neg   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
`ifdef MUL_SIGNED_EN
                        mcand <= mag_a;
                        prod  <= {{N{1'b0}}, mag_b};
                        neg   <= bus.in_a[N-1] ^ bus.in_b[N-1];
`else
                        mcand <= bus.in_a;
                        prod  <= {{N{1'b0}}, bus.in_b};
`endif
                        count <= '0;
                    end
                end
                CALC: begin
                    // Adder carry becomes the new top bit, so no product bit is lost.
                    prod  <= {c_out, sum, prod[N-1:1]};
                    count <= count + CW'(1);
                end
`ifdef MUL_SIGNED_EN
                FIX: begin
                    if (neg) prod <= ~prod + (2*N)'(1);
                end
`endif
                default: ;
            endcase
        end
    end

    assign bus.out_prod = prod;

endmodule

// File: tb/tb_mul_shift_add.sv
// Self-checking bench: N=8 and N=32 multipliers against an arithmetic reference model.
module tb_mul_shift_add;

`ifdef MUL_SIGNED_EN
    localparam int SIGNED = 1;
`else
    localparam int SIGNED = 0;
`endif

    logic clk;
    logic rst_n;
    int   total  = 0;
    int   passed = 0;

    mul_shift_add_if #(.N(8))  b8 ();
    mul_shift_add_if #(.N(32)) b32 ();

    mul_shift_add #(.N(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(b8.slave));
    mul_shift_add #(.N(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic int width_of(input int w);
        return (w == 0) ? 8 : 32;
    endfunction

    // Reference: sign/zero-extend to 64 bits, multiply, keep the low 2N bits.
    function automatic logic [63:0] model(input int w, input logic [31:0] a, input logic [31:0] b);
        int          n = width_of(w);
        logic [63:0] mask_n = (64'd1 << n) - 64'd1;
        logic [63:0] ua = {32'd0, a} & mask_n;
        logic [63:0] ub = {32'd0, b} & mask_n;
        logic [63:0] p;
        if (SIGNED != 0 && a[n-1]) ua = ua | ~mask_n;
        if (SIGNED != 0 && b[n-1]) ub = ub | ~mask_n;
        p = ua * ub;
        return (n == 32) ? p : (p & 64'hFFFF);
    endfunction

    function automatic logic f_ready(input int w);
        return (w == 0) ? b8.in_ready : b32.in_ready;
    endfunction

    function automatic logic f_valid(input int w);
        return (w == 0) ? b8.out_valid : b32.out_valid;
    endfunction

    function automatic logic [63:0] f_prod(input int w);
        return (w == 0) ? {48'd0, b8.out_prod} : b32.out_prod;
    endfunction

    task automatic drive(input int w, input logic v, input logic [31:0] a, input logic [31:0] b);
        if (w == 0) begin
            b8.in_valid = v;
            b8.in_a     = a[7:0];
            b8.in_b     = b[7:0];
        end else begin
            b32.in_valid = v;
            b32.in_a     = a;
            b32.in_b     = b;
        end
    endtask

    task automatic set_out_ready(input int w, input logic r);
        if (w == 0) b8.out_ready = r;
        else        b32.out_ready = r;
    endtask

    // One full transaction; junk operands stay valid during CALC/DONE to prove they are ignored.
    task automatic do_op(input int w, input logic [31:0] a, input logic [31:0] b,
                         input int stall, output logic [63:0] prod);
        int          lat = width_of(w) + SIGNED;
        logic [63:0] exp = model(w, a, b);
        int          edges;
        bit          ready_low;
        bit          stable;

        edges = 0;
        while (!f_ready(w) && edges < 100) begin
            @(negedge clk);
            edges++;
        end
        check("idle_ready", {63'd0, f_ready(w)}, 64'd1);

        drive(w, 1'b1, a, b);
        @(posedge clk);
        @(negedge clk);
        drive(w, 1'b1, ~a, ~b);

        edges     = 0;
        ready_low = 1'b1;
        while (!f_valid(w) && edges < lat + 4) begin
            if (f_ready(w)) ready_low = 1'b0;
            @(posedge clk);
            @(negedge clk);
            edges++;
        end
        check("latency", 64'(edges), 64'(lat));
        check("in_ready_low", {63'd0, ready_low}, 64'd1);
        check("prod", f_prod(w), exp);
        prod = f_prod(w);

        stable = 1'b1;
        set_out_ready(w, 1'b0);
        repeat (stall) begin
            @(posedge clk);
            @(negedge clk);
            if (!f_valid(w) || f_prod(w) !== exp) stable = 1'b0;
        end
        if (stall > 0) check("stall_stable", {63'd0, stable}, 64'd1);

        drive(w, 1'b0, a, b);
        set_out_ready(w, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_out_ready(w, 1'b0);
        check("handoff_valid", {63'd0, f_valid(w)}, 64'd0);
        check("handoff_ready", {63'd0, f_ready(w)}, 64'd1);
        check("prod_held", f_prod(w), exp);
    endtask

    initial begin
        logic [63:0] p;
        logic [31:0] a;
        logic [31:0] b;
        bit          quiet;

        rst_n = 1'b0;
        drive(0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 32'd0, 32'd0);
        set_out_ready(0, 1'b0);
        set_out_ready(1, 1'b0);
        repeat (2) @(negedge clk);

        for (int w = 0; w < 2; w++) begin
            check("rst_in_ready", {63'd0, f_ready(w)}, 64'd1);
            check("rst_out_valid", {63'd0, f_valid(w)}, 64'd0);
            check("rst_out_prod", f_prod(w), 64'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        do_op(0, 32'd13, 32'd11, 0, p);
        check("p13x11", p, 64'd143);
        do_op(0, 32'd255, 32'd255, 0, p);
        check("p255x255", p, (SIGNED != 0) ? 64'd1 : 64'd65025);
        do_op(1, 32'd0, 32'hFFFF_FFFF, 0, p);
        check("p0xmax", p, 64'd0);
        do_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, p);
        check("pmaxxmax", p, (SIGNED != 0) ? 64'd1 : 64'hFFFF_FFFE_0000_0001);
        do_op(0, 32'd100, 32'd3, 5, p);
        check("p100x3", p, 64'd300);

        // Reset lands on the third CALC edge of an N=8 operation.
        drive(0, 1'b1, 32'd13, 32'd11);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 32'd0, 32'd0);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", {63'd0, f_ready(0)}, 64'd1);
        check("midrst_out_valid", {63'd0, f_valid(0)}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (f_valid(0) || !f_ready(0)) quiet = 1'b0;
        end
        check("midrst_quiet", {63'd0, quiet}, 64'd1);

        do_op(0, 32'd7, 32'd6, 0, p);
        check("p7x6", p, 64'd42);

`ifdef MUL_SIGNED_EN
        do_op(0, 32'h80, 32'h80, 0, p);
        check("pm128xm128", p, 64'd16384);
        do_op(0, 32'hFD, 32'd5, 0, p);
        check("pm3x5", p, 64'hFFF1);
`endif

        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: a = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: a = 32'h8000_0080;
                default: ;
            endcase
            do_op(i % 2, a, b, int'($urandom_range(0, 3)), p);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
